// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller:
// FSM states, opcode/ext fields, condition codes, PSR bit positions, result selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM_RD,
    MEM_WB,
    MEM_WR
  } state_t;

  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hB;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [1:0] RES_SHIFT = 2'd0;
  localparam logic [1:0] RES_ALU   = 2'd1;
  localparam logic [1:0] RES_PC    = 2'd2;
  localparam logic [1:0] RES_LINK  = 2'd3;

  // Logical immediates (ANDI/ORI/XORI) take a zero-extended immediate.
  function automatic logic is_logical_imm(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
  endfunction

endpackage

// File: rtl/cpu_controller_cond_check.sv
// Combinational branch/jump condition evaluator: decodes a 4-bit condition
// code against the datapath PSR flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [7:0] i_psr,
  output logic       o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;
  logic w_unused_psr;

  assign w_c = i_psr[PSR_C];
  assign w_l = i_psr[PSR_L];
  assign w_f = i_psr[PSR_F];
  assign w_z = i_psr[PSR_Z];
  assign w_n = i_psr[PSR_N];
  assign w_unused_psr = ^{i_psr[4:3], i_psr[1]};

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_EQ: o_taken = w_z;
      CC_NE: o_taken = !w_z;
      CC_CS: o_taken = w_c;
      CC_CC: o_taken = !w_c;
      CC_HI: o_taken = w_l;
      CC_LS: o_taken = !w_l;
      CC_GT: o_taken = w_n;
      CC_LE: o_taken = !w_n;
      CC_FS: o_taken = w_f;
      CC_FC: o_taken = !w_f;
      CC_LO: o_taken = !w_l && !w_z;
      CC_HS: o_taken = w_l || w_z;
      CC_LT: o_taken = !w_n && !w_z;
      CC_GE: o_taken = w_n || w_z;
      CC_UC: o_taken = 1'b1;
      CC_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch, decode, execute and
// memory sequencing, with every datapath control decoded from state and ir.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic [7:0]       PSR,
  output logic             PCEN,
  output logic             PSREN,
  output logic             nextInstruction,
  output logic             updateAddress,
  output logic             StoreReg,
  output logic             WriteData,
  output logic             regWrite,
  output logic             ZeroExtend,
  output logic             PCinstruction,
  output logic             SrcB,
  output logic             shiftType,
  output logic             jumpEN,
  output logic             BranchEN,
  output logic             jalEN,
  output logic [3:0]       ALUcond,
  output logic [1:0]       chooseResult,
  output logic             memWrite,
  output logic             instrDone
);

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_ir;
  logic [3:0]       w_op, w_rd, w_ext, w_alu_sel;
  logic             w_is_alu, w_taken, w_unused_rs;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:8];
  assign w_ext = r_ir[7:4];
  assign w_unused_rs = ^r_ir[3:0];

  // Every opcode except 0100/1000/1100 is an ALU op; 0000 is the register form.
  assign w_is_alu  = (w_op == OP_REG) || (w_op[1:0] != 2'b00);
  assign w_alu_sel = (w_op == OP_REG) ? w_ext : w_op;

  cond_check u_cond_check (
    .i_cond  (w_rd),
    .i_psr   (PSR),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (nextInstruction) r_ir <= memdata;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    PCEN            = 1'b0;
    PSREN           = 1'b0;
    nextInstruction = 1'b0;
    updateAddress   = 1'b0;
    StoreReg        = 1'b0;
    WriteData       = 1'b0;
    regWrite        = 1'b0;
    ZeroExtend      = 1'b0;
    PCinstruction   = 1'b0;
    SrcB            = 1'b0;
    shiftType       = 1'b0;
    jumpEN          = 1'b0;
    BranchEN        = 1'b0;
    jalEN           = 1'b0;
    ALUcond         = 4'h0;
    chooseResult    = RES_SHIFT;
    memWrite        = 1'b0;
    instrDone       = 1'b0;
    case (r_state)
      FETCH: begin
        updateAddress = 1'b1;
        w_next_state  = DECODE;
      end
      DECODE: begin
        updateAddress   = 1'b1;
        nextInstruction = 1'b1;
        w_next_state    = EXEC;
      end
      EXEC: begin
        instrDone    = 1'b1;
        w_next_state = FETCH;
        if (w_is_alu) begin
          ALUcond      = w_alu_sel;
          SrcB         = (w_op == OP_REG);
          ZeroExtend   = is_logical_imm(w_op);
          chooseResult = RES_ALU;
          WriteData    = 1'b1;
          PSREN        = 1'b1;
          PCEN         = 1'b1;
          regWrite     = (w_alu_sel != OP_CMP);
        end else if (w_op == OP_SHIFT) begin
          shiftType = w_ext[0];
          WriteData = 1'b1;
          regWrite  = 1'b1;
          PCEN      = 1'b1;
        end else if (w_op == OP_BCOND) begin
          PCinstruction = 1'b1;
          PCEN          = 1'b1;
          BranchEN      = w_taken;
        end else begin
          // OP_MEM group: the ext field selects the operation.
          case (w_ext)
            EXT_LOAD: begin
              instrDone    = 1'b0;
              w_next_state = MEM_RD;
            end
            EXT_STOR: begin
              instrDone    = 1'b0;
              w_next_state = MEM_WR;
            end
            EXT_JCOND: begin
              PCEN   = 1'b1;
              jumpEN = w_taken;
            end
            EXT_JAL: begin
              regWrite     = 1'b1;
              WriteData    = 1'b1;
              chooseResult = RES_LINK;
              jalEN        = 1'b1;
              jumpEN       = 1'b1;
              PCEN         = 1'b1;
            end
            default: PCEN = 1'b1;
          endcase
        end
      end
      MEM_RD: begin
        w_next_state = MEM_WB;
      end
      MEM_WB: begin
        regWrite     = 1'b1;
        PCEN         = 1'b1;
        instrDone    = 1'b1;
        w_next_state = FETCH;
      end
      MEM_WR: begin
        StoreReg     = 1'b1;
        memWrite     = 1'b1;
        PCEN         = 1'b1;
        instrDone    = 1'b1;
        w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed vector table, hand-written
// reset/memory sequences, and random instructions against a per-cycle model.
module tb_cpu_controller;

  typedef logic [21:0] ctl_t;

  localparam ctl_t M_PCEN = 22'(1) << 21;
  localparam ctl_t M_PSREN = 22'(1) << 20;
  localparam ctl_t M_NI   = 22'(1) << 19;
  localparam ctl_t M_UA   = 22'(1) << 18;
  localparam ctl_t M_SR   = 22'(1) << 17;
  localparam ctl_t M_WD   = 22'(1) << 16;
  localparam ctl_t M_RW   = 22'(1) << 15;
  localparam ctl_t M_ZE   = 22'(1) << 14;
  localparam ctl_t M_PCI  = 22'(1) << 13;
  localparam ctl_t M_SRCB = 22'(1) << 12;
  localparam ctl_t M_ST   = 22'(1) << 11;
  localparam ctl_t M_JE   = 22'(1) << 10;
  localparam ctl_t M_BE   = 22'(1) << 9;
  localparam ctl_t M_JAL  = 22'(1) << 8;
  localparam ctl_t M_MW   = 22'(1) << 1;
  localparam ctl_t M_DONE = 22'(1) << 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memdata;
  logic [7:0]  PSR;
  logic PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite;
  logic ZeroExtend, PCinstruction, SrcB, shiftType, jumpEN, BranchEN, jalEN;
  logic [3:0] ALUcond;
  logic [1:0] chooseResult;
  logic memWrite, instrDone;

  int tests = 0;
  int fails = 0;
  ctl_t trace_q[8];

  always #5 clk = ~clk;

  cpu_controller #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .memdata(memdata), .PSR(PSR),
    .PCEN(PCEN), .PSREN(PSREN), .nextInstruction(nextInstruction),
    .updateAddress(updateAddress), .StoreReg(StoreReg), .WriteData(WriteData),
    .regWrite(regWrite), .ZeroExtend(ZeroExtend), .PCinstruction(PCinstruction),
    .SrcB(SrcB), .shiftType(shiftType), .jumpEN(jumpEN), .BranchEN(BranchEN),
    .jalEN(jalEN), .ALUcond(ALUcond), .chooseResult(chooseResult),
    .memWrite(memWrite), .instrDone(instrDone)
  );

  function automatic ctl_t f_alu(input logic [3:0] a);
    return ctl_t'(a) << 4;
  endfunction

  function automatic ctl_t f_cr(input logic [1:0] r);
    return ctl_t'(r) << 2;
  endfunction

  function automatic ctl_t sample();
    return {PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite,
            ZeroExtend, PCinstruction, SrcB, shiftType, jumpEN, BranchEN, jalEN,
            ALUcond, chooseResult, memWrite, instrDone};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Flag truth table indexed by condition code.
  function automatic logic cond_taken(input logic [3:0] cc, input logic [7:0] p);
    logic c, l, f, z, n;
    logic [15:0] t;
    c = p[0]; l = p[2]; f = p[5]; z = p[6]; n = p[7];
    t = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f, ~n, n, ~l, l, ~c, c, ~z, z};
    return t[cc];
  endfunction

  function automatic int model_len(input logic [15:0] ins);
    if (ins[15:12] == 4'h4 && ins[7:4] == 4'h0) return 5;
    if (ins[15:12] == 4'h4 && ins[7:4] == 4'h4) return 4;
    return 3;
  endfunction

  function automatic ctl_t model_cycle(input logic [15:0] ins, input logic [7:0] p, input int c);
    logic [3:0] op, rd, ext, a;
    int len;
    ctl_t v;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4];
    len = model_len(ins);
    v = '0;
    if (c == 0) return M_UA;
    if (c == 1) return M_UA | M_NI;
    if (c == len - 1) v |= M_DONE;
    if (c == 2) begin
      if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF}) begin
        a = (op == 4'h0) ? ext : op;
        v |= M_PCEN | M_PSREN | M_WD | f_alu(a) | f_cr(2'd1);
        if (a != 4'hB) v |= M_RW;
        if (op == 4'h0) v |= M_SRCB;
        if (op inside {4'h1, 4'h2, 4'h3}) v |= M_ZE;
      end else if (op == 4'h8) begin
        v |= M_PCEN | M_WD | M_RW | (ext[0] ? M_ST : '0);
      end else if (op == 4'hC) begin
        v |= M_PCEN | M_PCI | (cond_taken(rd, p) ? M_BE : '0);
      end else if (ext == 4'hC) begin
        v |= M_PCEN | (cond_taken(rd, p) ? M_JE : '0);
      end else if (ext == 4'h8) begin
        v |= M_PCEN | M_RW | M_WD | f_cr(2'd3) | M_JAL | M_JE;
      end else if (ext != 4'h0 && ext != 4'h4) begin
        v |= M_PCEN;
      end
    end
    if (c == 3 && len == 4) v |= M_PCEN | M_SR | M_MW;
    if (c == 4) v |= M_PCEN | M_RW;
    return v;
  endfunction

  // Entry: just after a rising edge with the DUT in FETCH. Exit: same phase,
  // back in FETCH. Checks every cycle against the model and records the trace.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] p, output int done_at);
    int len;
    ctl_t act;
    len = model_len(ins);
    done_at = 0;
    memdata = ins;
    PSR = p;
    for (int c = 0; c < 8; c++) trace_q[c] = '0;
    for (int c = 0; c < len; c++) begin
      if (c >= 2) memdata = 16'($urandom);
      @(negedge clk);
      act = sample();
      trace_q[c] = act;
      check($sformatf("cycle instr=%h psr=%h cyc=%0d", ins, p, c), 32'(act),
            32'(model_cycle(ins, p, c)));
      if (act[0] && done_at == 0) done_at = c + 1;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  psr;
    int          cycles;
    ctl_t        exec_v;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int   done_at, n_pcen, n_rw, n_psren, n_mw, len;
    logic [15:0] ins;
    ctl_t act;

    tbl[0]  = '{16'h5107, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | M_RW | f_alu(4'h5) | f_cr(2'd1)};
    tbl[1]  = '{16'h0153, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | M_RW | M_SRCB | f_alu(4'h5) | f_cr(2'd1)};
    tbl[2]  = '{16'h2345, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | M_RW | M_ZE | f_alu(4'h2) | f_cr(2'd1)};
    tbl[3]  = '{16'hB012, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | f_alu(4'hB) | f_cr(2'd1)};
    tbl[4]  = '{16'h01B2, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | M_SRCB | f_alu(4'hB) | f_cr(2'd1)};
    tbl[5]  = '{16'h8311, 8'h00, 3, M_PCEN | M_DONE | M_WD | M_RW | M_ST};
    tbl[6]  = '{16'h4302, 8'h00, 5, '0};
    tbl[7]  = '{16'h4345, 8'h00, 4, '0};
    tbl[8]  = '{16'hC0FC, 8'h40, 3, M_PCEN | M_DONE | M_PCI | M_BE};
    tbl[9]  = '{16'hC0FC, 8'h00, 3, M_PCEN | M_DONE | M_PCI};
    tbl[10] = '{16'h4F8A, 8'h00, 3, M_PCEN | M_DONE | M_RW | M_WD | f_cr(2'd3) | M_JAL | M_JE};
    tbl[11] = '{16'h4070, 8'h00, 3, M_PCEN | M_DONE};
    tbl[12] = '{16'h4ECA, 8'h00, 3, M_PCEN | M_DONE | M_JE};
    tbl[13] = '{16'h4FCA, 8'hFF, 3, M_PCEN | M_DONE};
    tbl[14] = '{16'hCAFE, 8'h00, 3, M_PCEN | M_DONE | M_PCI | M_BE};
    tbl[15] = '{16'hCAFE, 8'h04, 3, M_PCEN | M_DONE | M_PCI};
    tbl[16] = '{16'h4DC1, 8'h80, 3, M_PCEN | M_DONE | M_JE};
    tbl[17] = '{16'h8200, 8'h00, 3, M_PCEN | M_DONE | M_WD | M_RW};
    tbl[18] = '{16'h7A55, 8'h00, 3, M_PCEN | M_DONE | M_PSREN | M_WD | M_RW | f_alu(4'h7) | f_cr(2'd1)};
    tbl[19] = '{16'hC503, 8'h04, 3, M_PCEN | M_DONE | M_PCI};

    reset = 1'b0;
    memdata = '0;
    PSR = '0;
    #1;
    check("reset outputs", 32'(sample()), 32'(M_UA));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (tbl[k]) begin
      run_instr(tbl[k].ins, tbl[k].psr, done_at);
      check($sformatf("latency instr=%h", tbl[k].ins), 32'(done_at), 32'(tbl[k].cycles));
      check($sformatf("exec vector instr=%h psr=%h", tbl[k].ins, tbl[k].psr),
            32'(trace_q[2]), 32'(tbl[k].exec_v));
    end

    // LOAD: MEM_RD is silent, MEM_WB writes the register with WriteData=0.
    run_instr(16'h4302, 8'h00, done_at);
    check("load MEM_RD", 32'(trace_q[3]), 32'(ctl_t'(0)));
    check("load MEM_WB", 32'(trace_q[4]), 32'(M_PCEN | M_RW | M_DONE));

    // STOR: a single MEM_WR cycle carrying the write strobe.
    run_instr(16'h4345, 8'h00, done_at);
    check("stor MEM_WR", 32'(trace_q[3]), 32'(M_PCEN | M_SR | M_MW | M_DONE));

    // Reset asserted in the middle of an ADD's EXEC cycle.
    memdata = 16'h0153;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    memdata = 16'hFFFF;
    #1;
    check("add EXEC regWrite before reset", 32'(regWrite), 32'(1));
    reset = 1'b0;
    #1;
    check("outputs right after reset assert", 32'(sample()), 32'(M_UA));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("outputs after reset release", 32'(sample()), 32'(M_UA));
    run_instr(16'h5107, 8'h00, done_at);
    check("ADDI after reset latency", 32'(done_at), 32'(3));

    for (int r = 0; r < 300; r++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ins[15:12] = 4'h4;
        ins[7:4] = 4'($urandom_range(0, 3) * 4);
      end
      len = model_len(ins);
      run_instr(ins, 8'($urandom), done_at);
      check($sformatf("random latency instr=%h", ins), 32'(done_at), 32'(len));
      n_pcen = 0; n_rw = 0; n_psren = 0; n_mw = 0;
      for (int c = 0; c < len; c++) begin
        act = trace_q[c];
        n_pcen += int'(act[21]);
        n_psren += int'(act[20]);
        n_rw += int'(act[15]);
        n_mw += int'(act[1]);
      end
      check($sformatf("PCEN once instr=%h", ins), 32'(n_pcen), 32'(1));
      check($sformatf("strobes at most once instr=%h", ins),
            32'((n_rw <= 1) && (n_psren <= 1) && (n_mw <= 1)), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
